// File: rtl/ahb_ram_slave_if.sv
// AHB-Lite slave front end for the byte-addressed data RAM: turns address/data-phase
// pipelining into single-cycle RAM strobes and produces the two-cycle ERROR response.
module ahb_ram_slave_if #(
    parameter int ADDR_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic        sel_1,
    output logic        rd_en_ram,
    output logic        wr_en_ram,
    output logic [31:0] address_ram,
    output logic [31:0] wr_data,
    output logic [2:0]  hsize_ram,
    input  logic [31:0] rd_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_RD_WAIT, S_RD_DATA, S_ERR1, S_ERR2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [2:0]           size_q, size_d;
    logic [31:0]          hrdata_q, hrdata_d;
    logic                 accept, bad;
    logic                 unused;

    assign unused = htrans[0];

    always_comb begin
        // Only the final cycle of a data phase can overlap the next address phase.
        accept = (state_q inside {S_IDLE, S_WRITE, S_RD_DATA, S_ERR2})
                 && hsel && hready && htrans[1];
        bad    = (hsize > 3'b010)
                 || (hsize == 3'b001 && haddr[0])
                 || (hsize == 3'b010 && haddr[1:0] != 2'b00)
                 || (haddr[31:ADDR_BITS] != '0);

        state_d  = S_IDLE;
        addr_d   = addr_q;
        size_d   = size_q;
        hrdata_d = hrdata_q;

        case (state_q)
            S_RD_WAIT: state_d = S_RD_DATA;
            S_ERR1:    state_d = S_ERR2;
            default: begin
                if (accept) begin
                    if (bad)         state_d = S_ERR1;
                    else if (hwrite) state_d = S_WRITE;
                    else             state_d = S_RD_WAIT;
                end
            end
        endcase

        if (accept) begin
            addr_d = haddr[ADDR_BITS-1:0];
            size_d = hsize;
        end
        if (state_q == S_RD_DATA) hrdata_d = rd_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Bus response depends on state alone; no combinational path from AHB inputs.
    always_comb begin
        hreadyout   = !(state_q inside {S_RD_WAIT, S_ERR1});
        hresp       = state_q inside {S_ERR1, S_ERR2};
        sel_1       = state_q inside {S_WRITE, S_RD_WAIT};
        wr_en_ram   = (state_q == S_WRITE);
        rd_en_ram   = (state_q == S_RD_WAIT);
        wr_data     = (state_q == S_WRITE) ? hwdata : 32'h0;
        address_ram = {{(32-ADDR_BITS){1'b0}}, addr_q};
        hsize_ram   = size_q;
        hrdata      = (state_q == S_RD_DATA) ? rd_data : hrdata_q;
    end

endmodule

// File: tb/tb_ahb_ram_slave_if.sv
// Directed bench for ahb_ram_slave_if with a behavioural byte RAM and a read-data scoreboard.
module tb_ahb_ram_slave_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        sel_1;
    logic        rd_en_ram;
    logic        wr_en_ram;
    logic [31:0] address_ram;
    logic [31:0] wr_data;
    logic [2:0]  hsize_ram;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    logic        ram_init;
    logic [7:0]  mem [64];
    logic [5:0]  ra;

    always #5 clk = ~clk;

    ahb_ram_slave_if #(.ADDR_BITS(6)) dut (
        .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .sel_1(sel_1),
        .rd_en_ram(rd_en_ram), .wr_en_ram(wr_en_ram), .address_ram(address_ram),
        .wr_data(wr_data), .hsize_ram(hsize_ram), .rd_data(rd_data)
    );

    // Byte-addressed RAM with registered, LSB-justified, zero-extended read data.
    assign ra = address_ram[5:0];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[0] <= 8'hAA; mem[1] <= 8'hBB; mem[2] <= 8'hCC; mem[3] <= 8'hDD;
            mem[4] <= 8'hEE;
            rd_data <= 32'h0;
        end else begin
            if (wr_en_ram) begin
                mem[ra] <= wr_data[7:0];
                if (hsize_ram != 3'b000) mem[6'(ra + 1)] <= wr_data[15:8];
                if (hsize_ram == 3'b010) begin
                    mem[6'(ra + 2)] <= wr_data[23:16];
                    mem[6'(ra + 3)] <= wr_data[31:24];
                end
            end
            if (rd_en_ram) begin
                case (hsize_ram)
                    3'b000:  rd_data <= {24'h0, mem[ra]};
                    3'b001:  rd_data <= {16'h0, mem[6'(ra + 1)], mem[ra]};
                    default: rd_data <= {mem[6'(ra + 3)], mem[6'(ra + 2)], mem[6'(ra + 1)], mem[ra]};
                endcase
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
        end else begin
            chk(tag, hrdata, exp_q.pop_front());
        end
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'b000; hready = 1'b1;
    endtask

    task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz; hready = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [31:0] err_addr [3];
    logic [2:0]  err_size [3];

    initial begin
        reset = 1'b1; ram_init = 1'b1; hwdata = 32'h0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1 ram_init = 1'b0;
        @(negedge clk);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_strobes", {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h0);
        chk("rst_address_ram", address_ram, 32'h0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_hsize_ram", 32'(hsize_ram), 32'h0);
        step(); reset = 1'b0;

        // Word read at 0: one wait state, then data.
        addr_ph(1'b0, 32'h0, 3'b010); exp_q.push_back(32'hDDCCBBAA);
        step(); bus_idle();
        @(negedge clk);
        chk("rd0_wait_hreadyout", 32'(hreadyout), 32'd0);
        chk("rd0_wait_strobes", {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'b110);
        chk("rd0_wait_hsize", 32'(hsize_ram), 32'd2);
        step(); @(negedge clk);
        chk("rd0_data_hreadyout", 32'(hreadyout), 32'd1);
        chk("rd0_data_hresp", 32'(hresp), 32'd0);
        pop_chk("rd0_hrdata");
        step(); @(negedge clk);
        chk("rd0_hrdata_held", hrdata, 32'hDDCCBBAA);
        chk("idle_strobes", {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h0);

        // Word write to 8 with a pipelined word read of 8.
        addr_ph(1'b1, 32'h8, 3'b010);
        step(); hwdata = 32'h12345678;
        addr_ph(1'b0, 32'h8, 3'b010); exp_q.push_back(32'h12345678);
        @(negedge clk);
        chk("wr8_hreadyout", 32'(hreadyout), 32'd1);
        chk("wr8_strobes", {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'b101);
        chk("wr8_address", address_ram, 32'h8);
        chk("wr8_wr_data", wr_data, 32'h12345678);
        step(); bus_idle();
        @(negedge clk);
        chk("rd8_wait_hreadyout", 32'(hreadyout), 32'd0);
        chk("rd8_wait_strobes", {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'b110);
        step(); @(negedge clk);
        pop_chk("rd8_hrdata");

        // Byte write 0xA5 to 9, then halfword read at 8.
        addr_ph(1'b1, 32'h9, 3'b000);
        step(); hwdata = 32'h000000A5;
        addr_ph(1'b0, 32'h8, 3'b001); exp_q.push_back(32'h0000A578);
        @(negedge clk);
        chk("wr9_address", address_ram, 32'h9);
        chk("wr9_hsize", 32'(hsize_ram), 32'd0);
        chk("wr9_wr_en", 32'(wr_en_ram), 32'd1);
        step(); bus_idle();
        @(negedge clk);
        chk("rdh8_wait_hreadyout", 32'(hreadyout), 32'd0);
        step(); @(negedge clk);
        pop_chk("rdh8_hrdata");
        step();

        // Misaligned halfword, out-of-range word, illegal size: two-cycle ERROR, no write.
        err_addr[0] = 32'h3;  err_size[0] = 3'b001;
        err_addr[1] = 32'h40; err_size[1] = 3'b010;
        err_addr[2] = 32'h0;  err_size[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            addr_ph(1'b1, err_addr[i], err_size[i]);
            step(); hwdata = 32'hFFFFFFFF; bus_idle();
            @(negedge clk);
            chk($sformatf("err%0d_c1_hreadyout", i), 32'(hreadyout), 32'd0);
            chk($sformatf("err%0d_c1_hresp", i), 32'(hresp), 32'd1);
            chk($sformatf("err%0d_c1_strobes", i), {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h0);
            step(); @(negedge clk);
            chk($sformatf("err%0d_c2_hreadyout", i), 32'(hreadyout), 32'd1);
            chk($sformatf("err%0d_c2_hresp", i), 32'(hresp), 32'd1);
            chk($sformatf("err%0d_c2_strobes", i), {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h0);
            step(); @(negedge clk);
            chk($sformatf("err%0d_after_hresp", i), 32'(hresp), 32'd0);
        end
        chk("err_mem3_intact", 32'(mem[3]), 32'hDD);
        chk("err_mem0_intact", 32'(mem[0]), 32'hAA);

        // NONSEQ while another slave stalls, then BUSY: nothing accepted.
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'hC; hsize = 3'b010; hready = 1'b0;
        step(); bus_idle();
        @(negedge clk);
        chk("stall_hreadyout", 32'(hreadyout), 32'd1);
        chk("stall_strobes", {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h0);
        hsel = 1'b1; htrans = 2'b01; hwrite = 1'b0; haddr = 32'h4; hsize = 3'b010; hready = 1'b1;
        step(); bus_idle();
        @(negedge clk);
        chk("busy_hreadyout", 32'(hreadyout), 32'd1);
        chk("busy_hresp", 32'(hresp), 32'd0);
        chk("busy_strobes", {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h0);

        // Reset during RD_WAIT drops the read; a later read of 4 works.
        addr_ph(1'b0, 32'h0, 3'b010);
        step(); bus_idle(); reset = 1'b1;
        step(); reset = 1'b0;
        @(negedge clk);
        chk("midrst_hreadyout", 32'(hreadyout), 32'd1);
        chk("midrst_hresp", 32'(hresp), 32'd0);
        chk("midrst_hrdata", hrdata, 32'h0);
        chk("midrst_strobes", {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h0);
        addr_ph(1'b0, 32'h4, 3'b010); exp_q.push_back(32'h000000EE);
        step(); bus_idle();
        @(negedge clk);
        chk("rd4_wait_hreadyout", 32'(hreadyout), 32'd0);
        step(); @(negedge clk);
        pop_chk("rd4_hrdata");
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
